// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder sequencer: drives one shared 4-bit adder slice, LSB nibble first,
// chaining the slice carry through a register and returning sum/cout/ovf over valid/ready.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] sum_next;

    // New nibble enters at the top, so after NSLICE shifts the LSB nibble sits at [3:0].
    assign sum_next = {slice_sum, sum_sh_q[WIDTH-1:4]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    sum_sh_d = '0;
                    carry_d  = cin;
                    cnt_d    = '0;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_sh_d = sum_next;
                a_sh_d   = {4'b0000, a_sh_q[WIDTH-1:4]};
                b_sh_d   = {4'b0000, b_sh_q[WIDTH-1:4]};
                carry_d  = slice_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    sum_d   = sum_next;
                    cout_d  = slice_cout;
                    ovf_d   = (a_msb_q == b_msb_q) && (slice_sum[3] != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        if (state_q == RUN) begin
            slice_a   = a_sh_q[3:0];
            slice_b   = b_sh_q[3:0];
            slice_cin = carry_q;
        end
    end

    // Gated with reset_n so in_ready is low for the whole time reset is held.
    assign in_ready  = (state_q == IDLE) && reset_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=16): directed vector table, multi-cycle corner
// sequences and random operations checked against plain-arithmetic expectations.
module tb_serial_add_ctrl;

    localparam int unsigned W = 16;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   slice_a;
    logic [3:0]   slice_b;
    logic         slice_cin;
    logic [3:0]   slice_sum;
    logic         slice_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_cin (slice_cin),
        .slice_sum (slice_sum),
        .slice_cout(slice_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    // Shared 4-bit adder slice.
    assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
        int           hold;
        bit           glitch;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic [W-1:0] esum, input logic ecout, input logic eovf,
                         input int hold, input bit glitch);
        int acc;
        int k;
        wait_ready();
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        cin = tc;
        @(negedge clk);
        acc = cyc;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        check("in_ready_in_run", {31'b0, in_ready}, 32'd0);
        if (glitch) begin
            a = 16'hAAAA;
            b = 16'hAAAA;
            cin = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        a = ~ta;
        b = ~tb_;
        cin = ~tc;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("out_valid_seen", {31'b0, out_valid}, 32'd1);
        check("latency", 32'(cyc - acc), 32'd4);
        check("sum", {16'b0, sum}, {16'b0, esum});
        check("cout", {31'b0, cout}, {31'b0, ecout});
        check("ovf", {31'b0, ovf}, {31'b0, eovf});
        check("slice_a_done", {28'b0, slice_a}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_sum", {16'b0, sum}, {16'b0, esum});
            check("hold_cout", {31'b0, cout}, {31'b0, ecout});
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid_drop", {31'b0, out_valid}, 32'd0);
        check("in_ready_back", {31'b0, in_ready}, 32'd1);
        check("busy_idle", {31'b0, busy}, 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        check("sum_retained", {16'b0, sum}, {16'b0, esum});
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   full;
        int           k;
        int           spurious;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 5, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b1};

        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_slice", {23'b0, slice_a, slice_b, slice_cin}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // out_ready while nothing is pending must not disturb IDLE.
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check("stray_out_ready_valid", {31'b0, out_valid}, 32'd0);
        check("stray_out_ready_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].esum,
                  vecs[i].ecout, vecs[i].eovf, vecs[i].hold, vecs[i].glitch);
        end

        // Reset at cnt=2: operation discarded, outputs cleared at once.
        wait_ready();
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("mid_rst_sum", {16'b0, sum}, 32'd0);
        check("mid_rst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
        check("mid_rst_slice", {23'b0, slice_a, slice_b, slice_cin}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || busy) spurious++;
        end
        check("no_result_after_rst", 32'(spurious), 32'd0);
        do_op(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);

        // Random operations against arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            k = int'($urandom_range(0, 2));
            do_op(ra, rb, rc, full[W-1:0], full[W],
                  (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]), k, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
